// File: rtl/dcache_arb_if.sv
// dcache_arb_if: both master request/response bundles plus the downstream memory port.
interface dcache_arb_if;
  logic [31:0] m0_addr_i, m0_data_wr_i, m1_addr_i, m1_data_wr_i;
  logic        m0_rd_i, m0_cacheable_i, m0_invalidate_i, m0_writeback_i, m0_flush_i;
  logic        m1_rd_i, m1_cacheable_i, m1_invalidate_i, m1_writeback_i, m1_flush_i;
  logic [3:0]  m0_wr_i, m1_wr_i;
  logic [10:0] m0_req_tag_i, m1_req_tag_i;
  logic        m0_accept_o, m0_ack_o, m0_error_o, m1_accept_o, m1_ack_o, m1_error_o;
  logic [31:0] m0_data_rd_o, m1_data_rd_o;
  logic [10:0] m0_resp_tag_o, m1_resp_tag_o;
  logic [31:0] mem_addr_o, mem_data_wr_o;
  logic        mem_rd_o, mem_cacheable_o, mem_invalidate_o, mem_writeback_o, mem_flush_o;
  logic [3:0]  mem_wr_o;
  logic [10:0] mem_req_tag_o;
  logic        mem_accept_i, mem_ack_i, mem_error_i;
  logic [31:0] mem_data_rd_i;
  logic [10:0] mem_resp_tag_i;
  logic        busy_o, spurious_ack_o;
  modport slave (
    input  m0_addr_i, m0_data_wr_i, m1_addr_i, m1_data_wr_i,
           m0_rd_i, m0_cacheable_i, m0_invalidate_i, m0_writeback_i, m0_flush_i,
           m1_rd_i, m1_cacheable_i, m1_invalidate_i, m1_writeback_i, m1_flush_i,
           m0_wr_i, m1_wr_i, m0_req_tag_i, m1_req_tag_i,
           mem_accept_i, mem_ack_i, mem_error_i, mem_data_rd_i, mem_resp_tag_i,
    output m0_accept_o, m0_ack_o, m0_error_o, m1_accept_o, m1_ack_o, m1_error_o,
           m0_data_rd_o, m1_data_rd_o, m0_resp_tag_o, m1_resp_tag_o,
           mem_addr_o, mem_data_wr_o, mem_rd_o, mem_cacheable_o, mem_invalidate_o,
           mem_writeback_o, mem_flush_o, mem_wr_o, mem_req_tag_o, busy_o, spurious_ack_o
  );
  modport master (
    output m0_addr_i, m0_data_wr_i, m1_addr_i, m1_data_wr_i,
           m0_rd_i, m0_cacheable_i, m0_invalidate_i, m0_writeback_i, m0_flush_i,
           m1_rd_i, m1_cacheable_i, m1_invalidate_i, m1_writeback_i, m1_flush_i,
           m0_wr_i, m1_wr_i, m0_req_tag_i, m1_req_tag_i,
           mem_accept_i, mem_ack_i, mem_error_i, mem_data_rd_i, mem_resp_tag_i,
    input  m0_accept_o, m0_ack_o, m0_error_o, m1_accept_o, m1_ack_o, m1_error_o,
           m0_data_rd_o, m1_data_rd_o, m0_resp_tag_o, m1_resp_tag_o,
           mem_addr_o, mem_data_wr_o, mem_rd_o, mem_cacheable_o, mem_invalidate_o,
           mem_writeback_o, mem_flush_o, mem_wr_o, mem_req_tag_o, busy_o, spurious_ack_o
  );
endinterface

// File: rtl/dcache_arb.sv
// dcache_arb: shares one data-cache memory port between two masters, routing in-order acks
// back to the issuer through an ID FIFO.
module dcache_arb #(
  parameter int OUTSTANDING = 4,
  parameter bit FIXED_PRIO  = 1'b0
) (
  input logic clk,
  input logic rst,
  dcache_arb_if.slave bus
);
  localparam int PW = $clog2(OUTSTANDING);
  logic [1:0] req;
  logic sel, full, acc, fire, pop, head, empty, fwd;
  logic lock_q, lock_d, lock_id_q, lock_id_d, last_q, last_d, spur_q, spur_d;
  logic [PW:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OUTSTANDING-1:0] ids_q;
  assign req[0] = bus.m0_rd_i | (|bus.m0_wr_i) | bus.m0_flush_i | bus.m0_invalidate_i | bus.m0_writeback_i;
  assign req[1] = bus.m1_rd_i | (|bus.m1_wr_i) | bus.m1_flush_i | bus.m1_invalidate_i | bus.m1_writeback_i;
  // With no requester (or both) the tie rule applies, so the idle grant is deterministic.
  assign sel   = lock_q ? lock_id_q : (req[0] ^ req[1]) ? req[1] : (FIXED_PRIO ? 1'b0 : ~last_q);
  assign full  = count_q == (PW+1)'(OUTSTANDING);
  assign empty = count_q == '0;
  assign acc   = bus.mem_accept_i & ~full;
  assign fire  = req[sel] & acc;
  assign pop   = bus.mem_ack_i & ~empty;
  assign head  = ids_q[rd_ptr_q];
  assign fwd   = ~full & (|req);
  assign bus.mem_addr_o        = sel ? bus.m1_addr_i : bus.m0_addr_i;
  assign bus.mem_data_wr_o     = sel ? bus.m1_data_wr_i : bus.m0_data_wr_i;
  assign bus.mem_req_tag_o     = sel ? bus.m1_req_tag_i : bus.m0_req_tag_i;
  assign bus.mem_cacheable_o   = sel ? bus.m1_cacheable_i : bus.m0_cacheable_i;
  assign bus.mem_rd_o          = fwd & (sel ? bus.m1_rd_i : bus.m0_rd_i);
  assign bus.mem_wr_o          = fwd ? (sel ? bus.m1_wr_i : bus.m0_wr_i) : 4'b0;
  assign bus.mem_invalidate_o  = fwd & (sel ? bus.m1_invalidate_i : bus.m0_invalidate_i);
  assign bus.mem_writeback_o   = fwd & (sel ? bus.m1_writeback_i : bus.m0_writeback_i);
  assign bus.mem_flush_o       = fwd & (sel ? bus.m1_flush_i : bus.m0_flush_i);
  assign bus.m0_accept_o       = acc & ~sel;
  assign bus.m1_accept_o       = acc & sel;
  assign bus.m0_ack_o          = pop & ~head;
  assign bus.m1_ack_o          = pop & head;
  assign bus.m0_error_o        = bus.mem_error_i & ~empty & ~head;
  assign bus.m1_error_o        = bus.mem_error_i & ~empty & head;
  assign bus.m0_data_rd_o      = bus.mem_data_rd_i;
  assign bus.m1_data_rd_o      = bus.mem_data_rd_i;
  assign bus.m0_resp_tag_o     = bus.mem_resp_tag_i;
  assign bus.m1_resp_tag_o     = bus.mem_resp_tag_i;
  assign bus.busy_o            = ~empty;
  assign bus.spurious_ack_o    = spur_q;
  always_comb begin
    lock_d    = fire ? 1'b0 : (req[sel] & ~acc) ? 1'b1 : lock_q;
    lock_id_d = lock_q ? lock_id_q : sel;
    last_d    = fire ? sel : last_q;
    count_d   = count_q + (PW+1)'(fire) - (PW+1)'(pop);
    spur_d    = spur_q | (bus.mem_ack_i & empty);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      last_q    <= 1'b1;
      spur_q    <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ids_q     <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      last_q    <= last_d;
      spur_q    <= spur_d;
      count_q   <= count_d;
      if (fire) begin
        ids_q[wr_ptr_q] <= sel;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end
endmodule

// File: tb/tb_dcache_arb.sv
// tb_dcache_arb: random traffic into a round-robin/depth-4 and a fixed-priority/depth-2 arbiter,
// each checked against a queue-based model of issuers and outstanding IDs.
module tb_dcache_arb;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  dcache_arb_if ba ();
  dcache_arb_if bb ();
  dcache_arb #(.OUTSTANDING(4), .FIXED_PRIO(1'b0)) u_rr (.clk(clk), .rst(rst), .bus(ba));
  dcache_arb #(.OUTSTANDING(2), .FIXED_PRIO(1'b1)) u_fp (.clk(clk), .rst(rst), .bus(bb));
  logic [31:0] addr [2], dwr [2];
  logic        rd [2], ca [2], inv [2], wb [2], fl [2];
  logic [3:0]  wr [2];
  logic [10:0] tag [2];
  logic        mem_acc, mem_ack, mem_err;
  logic [31:0] mrd;
  logic [10:0] mtag;
  assign ba.m0_addr_i = addr[0]; assign ba.m1_addr_i = addr[1];
  assign bb.m0_addr_i = addr[0]; assign bb.m1_addr_i = addr[1];
  assign ba.m0_data_wr_i = dwr[0]; assign ba.m1_data_wr_i = dwr[1];
  assign bb.m0_data_wr_i = dwr[0]; assign bb.m1_data_wr_i = dwr[1];
  assign ba.m0_rd_i = rd[0]; assign ba.m1_rd_i = rd[1]; assign bb.m0_rd_i = rd[0]; assign bb.m1_rd_i = rd[1];
  assign ba.m0_cacheable_i = ca[0]; assign ba.m1_cacheable_i = ca[1];
  assign bb.m0_cacheable_i = ca[0]; assign bb.m1_cacheable_i = ca[1];
  assign ba.m0_invalidate_i = inv[0]; assign ba.m1_invalidate_i = inv[1];
  assign bb.m0_invalidate_i = inv[0]; assign bb.m1_invalidate_i = inv[1];
  assign ba.m0_writeback_i = wb[0]; assign ba.m1_writeback_i = wb[1];
  assign bb.m0_writeback_i = wb[0]; assign bb.m1_writeback_i = wb[1];
  assign ba.m0_flush_i = fl[0]; assign ba.m1_flush_i = fl[1]; assign bb.m0_flush_i = fl[0]; assign bb.m1_flush_i = fl[1];
  assign ba.m0_wr_i = wr[0]; assign ba.m1_wr_i = wr[1]; assign bb.m0_wr_i = wr[0]; assign bb.m1_wr_i = wr[1];
  assign ba.m0_req_tag_i = tag[0]; assign ba.m1_req_tag_i = tag[1];
  assign bb.m0_req_tag_i = tag[0]; assign bb.m1_req_tag_i = tag[1];
  assign ba.mem_accept_i = mem_acc; assign ba.mem_ack_i = mem_ack; assign ba.mem_error_i = mem_err;
  assign bb.mem_accept_i = mem_acc; assign bb.mem_ack_i = mem_ack; assign bb.mem_error_i = mem_err;
  assign ba.mem_data_rd_i = mrd; assign ba.mem_resp_tag_i = mtag;
  assign bb.mem_data_rd_i = mrd; assign bb.mem_resp_tag_i = mtag;
  logic [1:0]  acc_o [2], ack_o [2], err_o [2];
  logic        busy_o [2], spur_o [2], mrd_o [2];
  logic [3:0]  mwr_o [2];
  logic [31:0] maddr_o [2], drd_o [2];
  logic [10:0] mtag_o [2], rtag_o [2];
  assign acc_o[0] = {ba.m1_accept_o, ba.m0_accept_o}; assign acc_o[1] = {bb.m1_accept_o, bb.m0_accept_o};
  assign ack_o[0] = {ba.m1_ack_o, ba.m0_ack_o};       assign ack_o[1] = {bb.m1_ack_o, bb.m0_ack_o};
  assign err_o[0] = {ba.m1_error_o, ba.m0_error_o};   assign err_o[1] = {bb.m1_error_o, bb.m0_error_o};
  assign busy_o[0] = ba.busy_o; assign busy_o[1] = bb.busy_o;
  assign spur_o[0] = ba.spurious_ack_o; assign spur_o[1] = bb.spurious_ack_o;
  assign mrd_o[0] = ba.mem_rd_o; assign mrd_o[1] = bb.mem_rd_o;
  assign mwr_o[0] = ba.mem_wr_o; assign mwr_o[1] = bb.mem_wr_o;
  assign maddr_o[0] = ba.mem_addr_o; assign maddr_o[1] = bb.mem_addr_o;
  assign mtag_o[0] = ba.mem_req_tag_o; assign mtag_o[1] = bb.mem_req_tag_o;
  assign drd_o[0] = ba.m1_data_rd_o ^ ba.m0_data_rd_o ^ ba.m0_data_rd_o; assign drd_o[1] = bb.m0_data_rd_o;
  assign rtag_o[0] = ba.m1_resp_tag_o; assign rtag_o[1] = bb.m0_resp_tag_o;
  int checks = 0, failures = 0;
  bit q [2][$];
  int held [2];
  bit last [2], spur [2];
  int depth [2] = '{4, 2};
  bit fixed [2] = '{1'b0, 1'b1};
  string nm [2] = '{"rr", "fp"};
  task automatic check(string t, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", t, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      q[k].delete();
      held[k] = -1;
      last[k] = 1'b1;
      spur[k] = 1'b0;
    end
  endtask
  task automatic step(int k);
    bit r [2];
    bit f, a, ne, h, fire;
    int s;
    for (int j = 0; j < 2; j++) r[j] = rd[j] | (wr[j] != 4'd0) | fl[j] | inv[j] | wb[j];
    f  = q[k].size() == depth[k];
    ne = q[k].size() > 0;
    h  = ne ? q[k][0] : 1'b0;
    s  = held[k] >= 0 ? held[k] : (r[0] != r[1]) ? int'(r[1]) : (fixed[k] ? 0 : 1 - int'(last[k]));
    a  = mem_acc & !f;
    fire = r[s] & a;
    check({nm[k], ".accept"}, 32'(acc_o[k]), a ? (s == 1 ? 32'd2 : 32'd1) : 32'd0);
    check({nm[k], ".ack"}, 32'(ack_o[k]), (ne && mem_ack) ? (h ? 32'd2 : 32'd1) : 32'd0);
    check({nm[k], ".error"}, 32'(err_o[k]), (ne && mem_err) ? (h ? 32'd2 : 32'd1) : 32'd0);
    check({nm[k], ".busy"}, 32'(busy_o[k]), 32'(ne));
    check({nm[k], ".spurious"}, 32'(spur_o[k]), 32'(spur[k]));
    check({nm[k], ".mem_rd"}, 32'(mrd_o[k]), (f || !(r[0] || r[1])) ? 32'd0 : 32'(rd[s]));
    check({nm[k], ".mem_wr"}, 32'(mwr_o[k]), (f || !(r[0] || r[1])) ? 32'd0 : 32'(wr[s]));
    check({nm[k], ".data_rd"}, drd_o[k], mrd);
    check({nm[k], ".resp_tag"}, 32'(rtag_o[k]), 32'(mtag));
    if (r[0] || r[1]) begin
      check({nm[k], ".mem_addr"}, maddr_o[k], addr[s]);
      check({nm[k], ".mem_tag"}, 32'(mtag_o[k]), 32'(tag[s]));
    end
    if (mem_ack && !ne) spur[k] = 1'b1;
    if (mem_ack && ne) void'(q[k].pop_front());
    if (fire) begin
      q[k].push_back(s[0]);
      last[k] = s[0];
      held[k] = -1;
    end else if (r[s] && !a) held[k] = s;
  endtask
  task automatic randomize_inputs();
    for (int j = 0; j < 2; j++) begin
      addr[j] = $urandom; dwr[j] = $urandom; tag[j] = 11'($urandom);
      rd[j]  = $urandom_range(0, 9) < 5;
      wr[j]  = $urandom_range(0, 9) < 2 ? 4'($urandom) : 4'd0;
      ca[j]  = 1'($urandom);
      inv[j] = $urandom_range(0, 19) == 0;
      wb[j]  = $urandom_range(0, 19) == 0;
      fl[j]  = $urandom_range(0, 19) == 0;
    end
    mem_acc = $urandom_range(0, 9) < 7;
    mem_ack = q[0].size() > 0 ? $urandom_range(0, 9) < 4 : $urandom_range(0, 49) == 0;
    mem_err = $urandom_range(0, 9) == 0;
    mrd = $urandom; mtag = 11'($urandom);
  endtask
  initial begin
    for (int j = 0; j < 2; j++) begin
      addr[j] = '0; dwr[j] = '0; tag[j] = '0; rd[j] = 0; wr[j] = '0;
      ca[j] = 0; inv[j] = 0; wb[j] = 0; fl[j] = 0;
    end
    mem_acc = 0; mem_ack = 0; mem_err = 0; mrd = '0; mtag = '0;
    model_reset();
    #12;
    for (int k = 0; k < 2; k++) begin
      check({nm[k], ".rst_busy"}, 32'(busy_o[k]), 32'd0);
      check({nm[k], ".rst_spur"}, 32'(spur_o[k]), 32'd0);
      check({nm[k], ".rst_accept"}, 32'(acc_o[k]), 32'd0);
      check({nm[k], ".rst_ack"}, 32'(ack_o[k]), 32'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 1000 == 999) begin
        rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
          check({nm[k], ".midrst_busy"}, 32'(busy_o[k]), 32'd0);
          check({nm[k], ".midrst_spur"}, 32'(spur_o[k]), 32'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
      end else begin
        randomize_inputs();
        #2;
        step(0);
        step(1);
        @(posedge clk); #1;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
